nn_train_sequencer: RTL and testbench

//  Top-level control FSM for the backprop neural-network core. Steps the shared
//  MAC/update datapath through forward pass (hidden, output), backward pass
//  (output error, hidden error) and weight update, one datapath transaction per

---
 rtl/nn_train_sequencer_pkg.sv | 41 ++++
 rtl/nn_train_sequencer_idx.sv | 30 +++
 rtl/nn_train_sequencer.sv | 148 ++++++++++++++
 tb/tb_nn_train_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_train_sequencer_pkg.sv
// Shared types and per-phase geometry for the backprop training sequencer.
package nn_train_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FWD_H = 3'd1,
    PH_FWD_O = 3'd2,
    PH_BWD_O = 3'd3,
    PH_BWD_H = 3'd4,
    PH_UPD_H = 3'd5,
    PH_UPD_O = 3'd6,
    PH_DONE  = 3'd7
  } phase_t;

  typedef struct packed {
    int unsigned neurons;
    int unsigned inputs;
  } dims_t;

  // Neurons x inputs stepped in each phase; idle phases report 1x1 so the
  // counters always see a sane limit.
  function automatic dims_t phase_dims(input phase_t ph,
                                       input int unsigned n_in,
                                       input int unsigned n_hid,
                                       input int unsigned n_out);
    dims_t d;
    d.neurons = 1;
    d.inputs  = 1;
    case (ph)
      PH_FWD_H: begin d.neurons = n_hid; d.inputs = n_in;  end
      PH_FWD_O: begin d.neurons = n_out; d.inputs = n_hid; end
      PH_BWD_O: begin d.neurons = n_out; d.inputs = 1;     end
      PH_BWD_H: begin d.neurons = n_hid; d.inputs = n_out; end
      PH_UPD_H: begin d.neurons = n_hid; d.inputs = n_in;  end
      PH_UPD_O: begin d.neurons = n_out; d.inputs = n_hid; end
      default:  begin d.neurons = 1;     d.inputs = 1;     end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/nn_train_sequencer_idx.sv
// Wrapping index counter: compare-to-limit wrap, no power-of-two assumption.
module nn_idx_counter #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [IDX_W:0]   limit,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);

  // Wrap is flagged on the advancing cycle that holds the last index.
  always_comb begin
    wrap = en && ({1'b0, idx} == (limit - (IDX_W+1)'(1)));
  end

  // Index register: clear wins, then advance/wrap on enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= wrap ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/nn_train_sequencer.sv
// Top-level control FSM for the backprop core: steps forward, backward and
// update phases one datapath transaction per handshake, for N epochs.
module nn_train_sequencer
  import nn_train_sequencer_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_HID   = 12,
  parameter int unsigned N_OUT   = 3,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               train,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  logic               abort,
  input  logic               dp_ack,
  output logic               dp_req,
  output logic               acc_clr,
  output logic [2:0]         phase,
  output logic [IDX_W-1:0]   neuron_idx,
  output logic [IDX_W-1:0]   input_idx,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               busy,
  output logic               done
);

  localparam int unsigned LIM_W = IDX_W + 1;

  phase_t             state, state_nxt;
  logic               dp_req_nxt;
  logic [EPOCH_W-1:0] epoch_nxt;
  logic               latch_run;
  logic               train_q;
  logic [EPOCH_W-1:0] epochs_q;
  logic [EPOCH_W-1:0] epochs_eff;
  logic               last_epoch;
  logic               ack;
  logic               cnt_clr;
  logic               in_wrap;
  logic               nr_wrap;
  logic [LIM_W-1:0]   in_lim;
  logic [LIM_W-1:0]   nr_lim;
  dims_t              dims;

  // Per-phase counter limits and handshake qualification (abort beats ack).
  always_comb begin
    dims       = phase_dims(state, N_IN, N_HID, N_OUT);
    in_lim     = LIM_W'(dims.inputs);
    nr_lim     = LIM_W'(dims.neurons);
    ack        = dp_req && dp_ack && !abort;
    cnt_clr    = (state == PH_IDLE) || (state == PH_DONE) || abort;
    epochs_eff = (epochs_q == '0) ? EPOCH_W'(1) : epochs_q;
    last_epoch = (epoch_cnt == epochs_eff - EPOCH_W'(1));
  end

  nn_idx_counter #(.IDX_W(IDX_W)) u_input_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (ack),
    .limit (in_lim),
    .idx   (input_idx),
    .wrap  (in_wrap)
  );

  nn_idx_counter #(.IDX_W(IDX_W)) u_neuron_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (in_wrap),
    .limit (nr_lim),
    .idx   (neuron_idx),
    .wrap  (nr_wrap)
  );

  // Next-state: phase sequencing, request valid and epoch bookkeeping.
  always_comb begin
    state_nxt  = state;
    dp_req_nxt = dp_req;
    epoch_nxt  = epoch_cnt;
    latch_run  = 1'b0;
    case (state)
      PH_IDLE: begin
        dp_req_nxt = 1'b0;
        if (start) begin
          state_nxt  = PH_FWD_H;
          dp_req_nxt = 1'b1;
          epoch_nxt  = '0;
          latch_run  = 1'b1;
        end
      end
      PH_DONE: begin
        state_nxt  = PH_IDLE;
        dp_req_nxt = 1'b0;
      end
      default: begin
        if (abort) begin
          state_nxt  = PH_IDLE;
          dp_req_nxt = 1'b0;
        end else if (nr_wrap) begin
          case (state)
            PH_FWD_H: state_nxt = PH_FWD_O;
            PH_FWD_O: state_nxt = train_q ? PH_BWD_O : PH_DONE;
            PH_BWD_O: state_nxt = PH_BWD_H;
            PH_BWD_H: state_nxt = PH_UPD_H;
            PH_UPD_H: state_nxt = PH_UPD_O;
            PH_UPD_O: begin
              epoch_nxt = epoch_cnt + EPOCH_W'(1);
              state_nxt = last_epoch ? PH_DONE : PH_FWD_H;
            end
            default:  state_nxt = PH_IDLE;
          endcase
          dp_req_nxt = (state_nxt != PH_DONE);
        end
      end
    endcase
  end

  // State, request, epoch and latched run configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PH_IDLE;
      dp_req    <= 1'b0;
      epoch_cnt <= '0;
      train_q   <= 1'b0;
      epochs_q  <= '0;
    end else begin
      state     <= state_nxt;
      dp_req    <= dp_req_nxt;
      epoch_cnt <= epoch_nxt;
      if (latch_run) begin
        train_q  <= train;
        epochs_q <= num_epochs;
      end
    end
  end

  // Status decodes of registered state.
  always_comb begin
    phase   = state;
    busy    = (state != PH_IDLE) && (state != PH_DONE);
    done    = (state == PH_DONE);
    acc_clr = dp_req && (input_idx == '0);
  end

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Scoreboard bench for nn_train_sequencer: expected transaction stream is
// queued at start and popped on every accepted handshake.
module tb_nn_train_sequencer;

  localparam int N_IN = 4, N_HID = 12, N_OUT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       train = 1'b0;
  logic [7:0] num_epochs = '0;
  logic       abort = 1'b0;
  logic       dp_ack = 1'b0;
  logic       dp_req, acc_clr, busy, done;
  logic [2:0] phase;
  logic [3:0] neuron_idx, input_idx;
  logic [7:0] epoch_cnt;

  typedef struct {
    logic [2:0] ph;
    logic [3:0] n;
    logic [3:0] i;
    logic [7:0] ep;
  } tx_t;

  tx_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  nn_train_sequencer #(.N_IN(4), .N_HID(12), .N_OUT(3), .IDX_W(4), .EPOCH_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .train      (train),
    .num_epochs (num_epochs),
    .abort      (abort),
    .dp_ack     (dp_ack),
    .dp_req     (dp_req),
    .acc_clr    (acc_clr),
    .phase      (phase),
    .neuron_idx (neuron_idx),
    .input_idx  (input_idx),
    .epoch_cnt  (epoch_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input bit t, input int epochs);
    int eff, nn, ni;
    eff = (epochs == 0 || !t) ? 1 : epochs;
    for (int e = 0; e < eff; e++) begin
      for (int p = 1; p <= (t ? 6 : 2); p++) begin
        case (p)
          1: begin nn = N_HID; ni = N_IN;  end
          2: begin nn = N_OUT; ni = N_HID; end
          3: begin nn = N_OUT; ni = 1;     end
          4: begin nn = N_HID; ni = N_OUT; end
          5: begin nn = N_HID; ni = N_IN;  end
          default: begin nn = N_OUT; ni = N_HID; end
        endcase
        for (int n = 0; n < nn; n++)
          for (int i = 0; i < ni; i++)
            exp_q.push_back('{ph: 3'(p), n: 4'(n), i: 4'(i), ep: 8'(e)});
      end
    end
  endtask

  task automatic start_run(input bit t, input int epochs);
    @(negedge clk);
    start = 1'b1; train = t; num_epochs = 8'(epochs); dp_ack = 1'b0; abort = 1'b0;
  endtask

  // Drives dp_ack with the given probability until the done pulse, popping
  // the scoreboard on each accepted transaction.
  task automatic run_check(input string name, input int ack_pct, input bit hold,
                           input int budget, output int ntx, output int nacc);
    bit pend, fin;
    logic [2:0] sp;
    logic [3:0] sn, si;
    tx_t e;
    int cyc;
    ntx = 0; nacc = 0; pend = 0; fin = 0; cyc = 0;
    sp = '0; sn = '0; si = '0;
    while (!fin) begin
      @(negedge clk);
      start = hold;
      if (pend) begin
        vectors++;
        if ({phase, neuron_idx, input_idx, dp_req} !== {sp, sn, si, 1'b1}) begin
          miscompares++;
          $display("FAIL %s hold: got ph=%0d n=%0d i=%0d req=%b need ph=%0d n=%0d i=%0d req=1",
                   name, phase, neuron_idx, input_idx, dp_req, sp, sn, si);
        end
      end
      vectors++;
      if (busy !== (phase != 3'd0 && phase != 3'd7) || acc_clr !== (dp_req && input_idx == 4'd0)) begin
        miscompares++;
        $display("FAIL %s status: got busy=%b acc_clr=%b at ph=%0d i=%0d req=%b",
                 name, busy, acc_clr, phase, input_idx, dp_req);
      end
      if (done === 1'b1) begin
        vectors++;
        if (exp_q.size() != 0 || dp_req !== 1'b0 || phase !== 3'd7) begin
          miscompares++;
          $display("FAIL %s done: got left=%0d req=%b ph=%0d need left=0 req=0 ph=7",
                   name, exp_q.size(), dp_req, phase);
        end
        fin = 1; dp_ack = 1'b0;
      end else begin
        dp_ack = ($urandom_range(0, 99) < ack_pct);
        if (dp_req === 1'b1 && dp_ack) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s extra_tx: got ph=%0d n=%0d i=%0d need none", name, phase, neuron_idx, input_idx);
          end else begin
            e = exp_q.pop_front();
            if ({phase, neuron_idx, input_idx, epoch_cnt} !== {e.ph, e.n, e.i, e.ep}) begin
              miscompares++;
              $display("FAIL %s tx%0d: got ph=%0d n=%0d i=%0d ep=%0d need ph=%0d n=%0d i=%0d ep=%0d",
                       name, ntx, phase, neuron_idx, input_idx, epoch_cnt, e.ph, e.n, e.i, e.ep);
            end
          end
          ntx++;
          if (acc_clr) nacc++;
        end
        pend = (dp_req === 1'b1) && !dp_ack;
        sp = phase; sn = neuron_idx; si = input_idx;
      end
      cyc++;
      if (!fin && cyc > budget) begin
        vectors++; miscompares++;
        $display("FAIL %s timeout: got no done after %0d cycles need done", name, cyc);
        fin = 1;
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({phase, dp_req, busy, done, acc_clr, neuron_idx, input_idx, epoch_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got ph=%0d req=%b busy=%b done=%b need all 0", phase, dp_req, busy, done);
    end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (phase !== 3'd0 || dp_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ph=%0d req=%b need 0/0", phase, dp_req);
    end
  endtask

  task automatic test_idle_ack();
    start = 1'b0; dp_ack = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({phase, dp_req, neuron_idx, input_idx} !== '0) begin
      miscompares++;
      $display("FAIL idle_ack: got ph=%0d req=%b n=%0d i=%0d need 0", phase, dp_req, neuron_idx, input_idx);
    end
    dp_ack = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bit found;
    start_run(1'b1, 1);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      start = 1'b0; dp_ack = 1'b1;
      if (phase == 3'd2 && neuron_idx == 4'd1) found = 1;
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (!found || {phase, dp_req, busy, done, neuron_idx, input_idx} !== '0) begin
      miscompares++;
      $display("FAIL reset_midrun: got found=%b ph=%0d req=%b busy=%b n=%0d i=%0d need ph=0 all 0",
               found, phase, dp_req, busy, neuron_idx, input_idx);
    end
    dp_ack = 1'b0;
    @(negedge clk); reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_forward_only();
    int ntx, nacc;
    push_exp(1'b0, 5);
    start_run(1'b0, 5);
    run_check("fwd_only", 100, 1'b0, 200, ntx, nacc);
    vectors++;
    if (ntx != 84 || nacc != 15) begin
      miscompares++;
      $display("FAIL fwd_only_count: got tx=%0d accclr=%0d need tx=84 accclr=15", ntx, nacc);
    end
    @(negedge clk);
    vectors++;
    if (phase !== 3'd0 || done !== 1'b0 || dp_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_only_after: got ph=%0d done=%b req=%b need 0/0/0", phase, done, dp_req);
    end
  endtask

  task automatic test_train_two_epochs();
    int ntx, nacc;
    push_exp(1'b1, 2);
    start_run(1'b1, 2);
    run_check("train2", 100, 1'b0, 600, ntx, nacc);
    vectors++;
    if (ntx != 414 || nacc != 2 * (N_HID + N_OUT + N_OUT + N_HID + N_HID + N_OUT) || epoch_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL train2_count: got tx=%0d accclr=%0d ep=%0d need tx=414 accclr=90 ep=2", ntx, nacc, epoch_cnt);
    end
    @(negedge clk);
    vectors++;
    if (phase !== 3'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL train2_after: got ph=%0d done=%b need 0/0", phase, done);
    end
  endtask

  task automatic test_random_ack();
    int ntx, nacc;
    push_exp(1'b1, 0);
    start_run(1'b1, 0);
    run_check("rand_ack", 50, 1'b0, 3000, ntx, nacc);
    vectors++;
    if (ntx != 207 || epoch_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL rand_ack_count: got tx=%0d ep=%0d need tx=207 ep=1", ntx, epoch_cnt);
    end
  endtask

  task automatic test_abort();
    bit found, saw_done;
    int ntx, nacc;
    start_run(1'b1, 2);
    found = 0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(negedge clk);
      start = 1'b0; dp_ack = 1'b1;
      if (phase == 3'd2 && neuron_idx == 4'd2 && input_idx == 4'd5 && epoch_cnt == 8'd1) begin
        found = 1; abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0; dp_ack = 1'b0;
    vectors++;
    if (!found || phase !== 3'd0 || dp_req !== 1'b0 || neuron_idx !== 4'd0 || input_idx !== 4'd0
        || done !== 1'b0 || epoch_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL abort: got found=%b ph=%0d req=%b n=%0d i=%0d done=%b ep=%0d need ph=0 req=0 idx=0 done=0 ep=1",
               found, phase, dp_req, neuron_idx, input_idx, done, epoch_cnt);
    end
    saw_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || phase !== 3'd0) saw_done = 1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL abort_quiet: got done/activity after abort need idle");
    end
    push_exp(1'b0, 1);
    start_run(1'b0, 1);
    run_check("abort_restart", 100, 1'b0, 200, ntx, nacc);
    vectors++;
    if (ntx != 84) begin
      miscompares++;
      $display("FAIL abort_restart_count: got tx=%0d need 84", ntx);
    end
  endtask

  task automatic test_back_to_back();
    int ntx, nacc;
    push_exp(1'b0, 1);
    start_run(1'b0, 1);
    run_check("held_start", 100, 1'b1, 200, ntx, nacc);
    @(negedge clk);
    vectors++;
    if (phase !== 3'd0 || dp_req !== 1'b0) begin
      miscompares++;
      $display("FAIL held_start_done_ignored: got ph=%0d req=%b need ph=0 req=0", phase, dp_req);
    end
    @(negedge clk);
    vectors++;
    if (phase !== 3'd1 || dp_req !== 1'b1 || neuron_idx !== 4'd0 || input_idx !== 4'd0 || epoch_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL held_start_restart: got ph=%0d req=%b n=%0d i=%0d ep=%0d need ph=1 req=1 0/0 ep=0",
               phase, dp_req, neuron_idx, input_idx, epoch_cnt);
    end
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (phase !== 3'd0) begin
      miscompares++;
      $display("FAIL held_start_cleanup: got ph=%0d need 0", phase);
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_idle_ack();
    test_reset_midrun();
    test_forward_only();
    test_train_two_epochs();
    test_random_ack();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
